// File: rtl/piece_bag_queue.sv
// piece_bag_queue: LFSR-driven next-piece generator with optional 7-bag (PIECE_BAG_EN) and preview queue
module piece_bag_queue #(
    parameter int          PREVIEW_DEPTH = 3,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       pickPiece,
    input  logic                       flush,
    output logic                       piece_valid,
    output logic [15:0]                blockstate_new,
    output logic [5:0]                 spriteindex_new,
    output logic [2:0]                 piece_id,
    output logic [3*PREVIEW_DEPTH-1:0] preview_ids,
    output logic                       queue_full
);
    localparam int          CAP  = PREVIEW_DEPTH + 1;
    localparam logic [2:0]  CAP3 = 3'(CAP);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    typedef enum logic {FILL, READY} state_t;

    state_t              state;
    logic [15:0]         lfsr;
    logic [3*CAP-1:0]    qv;
    logic [3*CAP-1:0]    q_shift;
    logic [3*CAP-1:0]    q_next;
    logic [2:0]          count;
    logic [2:0]          count_next;
    logic [2:0]          widx;
    logic                pend;
    logic                push;
    logic                pop;
    logic [2:0]          cand;
    logic [6:0]          bag_now;
    logic [13:0]         bag2;
    logic [6:0]          rot;
    logic [2:0]          off;
    logic [3:0]          sum;
    logic [2:0]          sel;
    logic [21:0]         rom_head;

    function automatic logic [21:0] piece_rom(input logic [2:0] id);
        case (id)
            3'd0:    return {16'h0027, 6'd41};
            3'd1:    return {16'h1111, 6'd43};
            3'd2:    return {16'h0322, 6'd38};
            3'd3:    return {16'h0311, 6'd40};
            3'd4:    return {16'h0033, 6'd44};
            3'd5:    return {16'h0036, 6'd39};
            3'd6:    return {16'h0063, 6'd42};
            default: return {16'hFFFF, 6'd0};
        endcase
    endfunction

    // Galois LFSR, free-running outside reset; flush deliberately does not reseed
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) lfsr <= SEED;
        else          lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    assign cand = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];

`ifdef PIECE_BAG_EN
    logic [6:0] bag;
    logic [6:0] bag_clr;
    assign bag_clr = bag & ~(7'd1 << sel);
    // Bag of still-available pieces; refills once the last one is drawn
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n)  bag <= 7'h7F;
        else if (flush) bag <= 7'h7F;
        else if (push)  bag <= (bag_clr == 7'h00) ? 7'h7F : bag_clr;
    assign bag_now = bag;
`else
    assign bag_now = 7'h7F;
`endif

    // Rotate the bag so the candidate sits at bit 0, then take the lowest set bit
    assign bag2 = {bag_now, bag_now};
    assign rot  = bag2[cand +: 7];

    // Priority encoder: offset from the candidate to the first available piece
    always_comb begin
        off = 3'd0;
        for (int k = 6; k >= 0; k--)
            if (rot[k]) off = 3'(k);
    end

    assign sum = {1'b0, cand} + {1'b0, off};
    assign sel = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];

    // A pending request is merged with a live one; pushing is free while filling
    assign pop  = !flush && (pickPiece || pend) && (count != 3'd0);
    assign push = !flush && ((state == FILL) || pop);
    assign widx = count - {2'b0, pop};

    // Next queue image: shift out the head, then append the drawn piece after the tail
    always_comb begin
        q_shift = pop ? {3'd7, qv[3*CAP-1:3]} : qv;
        q_next  = q_shift;
        if (push) q_next[3*int'(widx) +: 3] = sel;
        count_next = flush ? 3'd0 : count + {2'b0, push} - {2'b0, pop};
    end

    // Queue storage, occupancy, pending request and fill/ready state
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            qv         <= '1;
            count      <= 3'd0;
            pend       <= 1'b0;
            state      <= FILL;
            queue_full <= 1'b0;
        end else begin
            qv         <= flush ? '1 : q_next;
            count      <= count_next;
            pend       <= flush ? 1'b0 : (count == 3'd0) ? (pend | pickPiece) : 1'b0;
            state      <= (count_next == CAP3) ? READY : FILL;
            queue_full <= (count_next == CAP3);
        end

    // Empty slots always hold 7, so the preview is a direct view of entries 1..depth
    assign preview_ids = qv[3*CAP-1:3];
    assign rom_head    = piece_rom(qv[2:0]);

    // Registered pop outputs; held between pops and across flush
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            piece_valid     <= 1'b0;
            blockstate_new  <= 16'hFFFF;
            spriteindex_new <= 6'd0;
            piece_id        <= 3'd0;
        end else begin
            piece_valid <= pop;
            if (pop) begin
                blockstate_new  <= rom_head[21:6];
                spriteindex_new <= rom_head[5:0];
                piece_id        <= qv[2:0];
            end
        end
endmodule

// File: tb/tb_piece_bag_queue.sv
// tb_piece_bag_queue: reference-model and scoreboard bench for piece_bag_queue
module tb_piece_bag_queue;
    localparam int PD  = 3;
    localparam int CAP = PD + 1;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          pickPiece;
    logic          flush;
    logic          piece_valid;
    logic [15:0]   blockstate_new;
    logic [5:0]    spriteindex_new;
    logic [2:0]    piece_id;
    logic [3*PD-1:0] preview_ids;
    logic          queue_full;

    piece_bag_queue #(.PREVIEW_DEPTH(PD)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pickPiece(pickPiece), .flush(flush),
        .piece_valid(piece_valid), .blockstate_new(blockstate_new),
        .spriteindex_new(spriteindex_new), .piece_id(piece_id),
        .preview_ids(preview_ids), .queue_full(queue_full)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    logic [15:0] pat_t [7] = '{16'h0027, 16'h1111, 16'h0322, 16'h0311, 16'h0033, 16'h0036, 16'h0063};
    int          spr_t [7] = '{41, 43, 38, 40, 44, 39, 42};

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [15:0] m_lfsr;
    logic [6:0]  m_bag;
    int          m_q[$];
    int          sb[$];
    bit          m_pend, m_valid, m_full;
    int          m_last;

    // Cycle model: draw, pop into the scoreboard, push, advance LFSR
    always @(posedge Clk or negedge Reset_n) begin
        int c, s, sz;
        bit p, u;
        if (!Reset_n) begin
            m_lfsr = 16'hACE1; m_bag = 7'h7F; m_q.delete(); sb.delete();
            m_pend = 0; m_valid = 0; m_full = 0; m_last = 0;
        end else begin
            c = int'(m_lfsr[2:0]);
            if (c == 7) c = 0;
            s = c;
`ifdef PIECE_BAG_EN
            while (!m_bag[s]) s = (s + 1) % 7;
`endif
            if (flush) begin
                m_q.delete(); m_bag = 7'h7F; m_pend = 0; m_valid = 0;
            end else begin
                sz = m_q.size();
                p = (pickPiece || m_pend) && sz > 0;
                u = sz < CAP || p;
                m_valid = p;
                if (p) begin
                    m_last = m_q.pop_front();
                    sb.push_back(m_last);
                end
                if (u) begin
                    m_q.push_back(s);
                    m_bag[s] = 1'b0;
                    if (m_bag == 7'h00) m_bag = 7'h7F;
                end
                m_pend = (sz == 0) ? (m_pend || pickPiece) : 1'b0;
            end
            m_full = (m_q.size() == CAP);
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Running comparison against the model, mid-cycle
    always @(negedge Clk) begin
        int ep, e;
        if (chk_en) begin
            chk("valid", int'(piece_valid), int'(m_valid));
            chk("full", int'(queue_full), int'(m_full));
            ep = 0;
            for (int i = PD; i >= 1; i--) ep = (ep << 3) | ((i < m_q.size()) ? m_q[i] : 7);
            chk("preview", int'(preview_ids), ep);
            if (piece_valid) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("sb_id", int'(piece_id), e);
                    chk("sb_pattern", int'(blockstate_new), int'(pat_t[e]));
                    chk("sb_sprite", int'(spriteindex_new), spr_t[e]);
                end
            end
        end
    end

    task automatic cyc(input logic p, input logic f);
        pickPiece = p;
        flush = f;
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic pick;
        logic fl;
        logic valid;
        logic full;
        int   free;
    } vec_t;

    function automatic int free_slots(input logic [3*PD-1:0] pv);
        int n = 0;
        for (int i = 0; i < PD; i++) if (pv[3*i +: 3] == 3'd7) n++;
        return n;
    endfunction

    initial begin
        vec_t tv[11];
        int   ids[14];
        int   pops, mask;
        tv[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0};
        tv[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0};
        tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0};
        tv[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0};
        tv[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 0};

        Reset_n = 1'b0; pickPiece = 1'b0; flush = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk_en = 1;
        chk("rst_pattern", int'(blockstate_new), 'hFFFF);
        chk("rst_sprite", int'(spriteindex_new), 0);
        chk("rst_id", int'(piece_id), 0);
        chk("rst_valid", int'(piece_valid), 0);
        chk("rst_full", int'(queue_full), 0);
        chk("rst_preview", int'(preview_ids), 'h1FF);
        Reset_n = 1'b1;

        for (int i = 1; i <= CAP; i++) begin
            cyc(0, 0);
            chk("fill_full", int'(queue_full), int'(i == CAP));
        end
        for (int i = 0; i < PD; i++) chk("fill_range", int'(preview_ids[3*i +: 3] <= 3'd6), 1);

        for (int i = 0; i < 14; i++) begin
            cyc(1, 0);
            ids[i] = int'(piece_id);
            chk("b2b_valid", int'(piece_valid), 1);
            chk("b2b_full", int'(queue_full), 1);
        end
        cyc(0, 0);
`ifdef PIECE_BAG_EN
        for (int g = 0; g < 2; g++) begin
            mask = 0;
            for (int i = 0; i < 7; i++) mask |= 1 << ids[7*g + i];
            chk("bag_perm", mask, 'h7F);
        end
`endif

        cyc(1, 1);
        chk("flushpri_valid", int'(piece_valid), 0);
        chk("flushpri_id", int'(piece_id), m_last);
        chk("flushpri_pattern", int'(blockstate_new), int'(pat_t[m_last]));
        chk("flushpri_sprite", int'(spriteindex_new), spr_t[m_last]);
        for (int i = 1; i <= CAP; i++) begin
            cyc(0, 0);
            chk("flushpri_full", int'(queue_full), int'(i == CAP));
        end

        foreach (tv[i]) begin
            cyc(tv[i].pick, tv[i].fl);
            chk("vec_valid", int'(piece_valid), int'(tv[i].valid));
            chk("vec_full", int'(queue_full), int'(tv[i].full));
            chk("vec_free", free_slots(preview_ids), tv[i].free);
        end

        cyc(0, 1);
        cyc(1, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 0);
            chk("pend_pulse", int'(piece_valid), int'(i == 1));
        end

        pops = 0;
        for (int i = 0; i < 3000 && pops < 64; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
            if (piece_valid) pops++;
        end
        cyc(0, 0);
        chk("rand_pops", int'(pops >= 64), 1);

        cyc(1, 0);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("arst_pattern", int'(blockstate_new), 'hFFFF);
        chk("arst_sprite", int'(spriteindex_new), 0);
        chk("arst_id", int'(piece_id), 0);
        chk("arst_valid", int'(piece_valid), 0);
        chk("arst_full", int'(queue_full), 0);
        chk("arst_preview", int'(preview_ids), 'h1FF);
        pickPiece = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (CAP + 2) cyc(0, 0);
        chk("refill_full", int'(queue_full), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
